// File: rtl/decode_execute_register.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures the decode-stage control word, operands, immediate, PC and rd,
// and presents them to execute one cycle later. Handles stall, flush and
// bubble insertion at this boundary, and holds a sticky illegal-instruction
// trap that squashes the pipeline until TrapClr is pulsed.
//
// Optional build macro: DE_BUBBLE_COUNT_EN adds a 32-bit BubbleCnt output
// counting bubbles caused by flush, trap entry and the TRAP state.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal operation: load, hold, flush or enter TRAP
// TRAP  | illegal op latched; bubble every cycle until TrapClr
module decode_execute_register #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              TrapClr,
  input  logic              ValidD,
  input  logic [7:0]        CtrlD,
  input  logic              IllegalOpD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [REG_AW-1:0] RdD,
  output logic              ValidE,
  output logic [7:0]        CtrlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [REG_AW-1:0] RdE,
  output logic              TrapE,
`ifdef DE_BUBBLE_COUNT_EN
  output logic [31:0]       BubbleCnt,
`endif
  output logic [XLEN-1:0]   TrapPC
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic              valid_q,   valid_d;
  logic [7:0]        ctrl_q,    ctrl_d;
  logic [XLEN-1:0]   rd1_q,     rd1_d;
  logic [XLEN-1:0]   rd2_q,     rd2_d;
  logic [XLEN-1:0]   imm_q,     imm_d;
  logic [XLEN-1:0]   pc_q,      pc_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  logic              trap_e_q,  trap_e_d;
  logic [XLEN-1:0]   trap_pc_q, trap_pc_d;

  // Load decisions for this edge; bubble and load are mutually exclusive,
  // neither set means hold (stall).
  logic load_bubble;
  logic load_data;
  // Bubble caused by flush, trap entry or TRAP state (not by ValidD = 0).
  logic count_bubble;

  // Next-state and register-update selection, highest priority first:
  // TRAP state, flush, stall, illegal op, empty slot, normal load.
  always_comb begin
    state_d      = state_q;
    trap_e_d     = trap_e_q;
    trap_pc_d    = trap_pc_q;
    load_bubble  = 1'b0;
    load_data    = 1'b0;
    count_bubble = 1'b0;

    unique case (state_q)
      TRAP: begin
        load_bubble  = 1'b1;
        count_bubble = 1'b1;
        trap_e_d     = 1'b1;
        if (TrapClr) begin
          state_d  = RUN;
          trap_e_d = 1'b0;
        end
      end
      default: begin
        if (FlushE) begin
          // Wrong-path instruction: any illegal flag is discarded.
          load_bubble  = 1'b1;
          count_bubble = 1'b1;
        end else if (StallE) begin
          load_bubble = 1'b0;
        end else if (ValidD && IllegalOpD) begin
          load_bubble  = 1'b1;
          count_bubble = 1'b1;
          trap_pc_d    = PCD;
          trap_e_d     = 1'b1;
          state_d      = TRAP;
        end else if (!ValidD) begin
          load_bubble = 1'b1;
        end else begin
          load_data = 1'b1;
        end
      end
    endcase
  end

  // E-stage payload mux: bubble zeroes everything, load copies D, else hold.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      rd_d    = '0;
    end else if (load_data) begin
      valid_d = 1'b1;
      ctrl_d  = CtrlD;
      rd1_d   = RD1D;
      rd2_d   = RD2D;
      imm_d   = ImmExtD;
      pc_d    = PCD;
      rd_d    = RdD;
    end
  end

  // Trap state machine register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      trap_e_q  <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_e_q  <= trap_e_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  // E-stage pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
    end
  end

`ifdef DE_BUBBLE_COUNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Free-running wrap-around count of squashing bubbles.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (count_bubble) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // Bubble counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign BubbleCnt = bubble_cnt_q;
`else
  // Counting is disabled; the qualifier is intentionally left unused.
  logic unused_count;
  assign unused_count = count_bubble;
`endif

  assign ValidE  = valid_q;
  assign CtrlE   = ctrl_q;
  assign RD1E    = rd1_q;
  assign RD2E    = rd2_q;
  assign ImmExtE = imm_q;
  assign PCE     = pc_q;
  assign RdE     = rd_q;
  assign TrapE   = trap_e_q;
  assign TrapPC  = trap_pc_q;

endmodule

// File: doc/decode_execute_register.md
Name: decode_execute_register

Overview:
- ID/EX pipeline register for the 5-stage RV32I core.
- Captures the decode-stage control outputs (RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl, IllegalOp) and the register-file, immediate and PC values.
- Presents them to the execute stage one cycle later.
- Owns stall, flush and bubble insertion for the ID/EX boundary, plus a sticky illegal-instruction trap state machine that squashes the pipeline until software/testbench clears it.

Parameters:
- XLEN, 32, data and PC width.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- StallE  input  1  hold all E-stage registers.
- FlushE  input  1  load a bubble.
- TrapClr  input  1  leave the TRAP state.
- ValidD  input  1  the D-stage slot holds a real instruction.
- CtrlD  input  8  {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}.
- IllegalOpD  input  1  illegal-op flag from the control unit.
- RD1D  input  XLEN  rs1 read data.
- RD2D  input  XLEN  rs2 read data.
- ImmExtD  input  XLEN  extended immediate.
- PCD  input  XLEN  instruction PC.
- RdD  input  REG_AW  destination register.
- ValidE  output  1  the E-stage slot holds a real instruction.
- CtrlE  output  8  registered CtrlD.
- RD1E  output  XLEN  registered RD1D.
- RD2E  output  XLEN  registered RD2D.
- ImmExtE  output  XLEN  registered ImmExtD.
- PCE  output  XLEN  registered PCD.
- RdE  output  REG_AW  registered RdD.
- TrapE  output  1  trap pending (sticky).
- TrapPC  output  XLEN  PC of the trapping instruction.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state = RUN. Reset mid-TRAP also returns to RUN with TrapE = 0.
- Latency: 1 cycle from D inputs to E outputs when not stalled.
- Bubble load: ValidE = 0, CtrlE = 0, RdE = 0, and RD1E/RD2E/ImmExtE/PCE = 0. A bubble never writes a register or memory.
- Update priority per edge, highest first: rst, state TRAP, FlushE, StallE, normal load.
- State RUN:
  - FlushE = 1: load a bubble. Any IllegalOpD is ignored because the instruction is on the wrong path. Flush beats Stall.
  - StallE = 1 (no flush): all E registers hold. IllegalOpD is not acted on until the instruction advances.
  - Normal, ValidD = 1 and IllegalOpD = 1: load a bubble (the illegal instruction never reaches E), TrapPC <= PCD, TrapE <= 1, next state TRAP.
  - Normal, ValidD = 0: load a bubble; IllegalOpD is don't-care.
  - Normal otherwise: load all D inputs, ValidE <= 1.
  - TrapClr is ignored in RUN.
- State TRAP:
  - Load a bubble every cycle, independent of StallE, FlushE and the D inputs.
  - TrapE stays 1 and TrapPC holds its value.
  - TrapClr = 1: next state RUN, TrapE <= 0. TrapPC keeps its last value. The bubble is still loaded on that edge, and the first real load happens the following edge.
- Only one trap is latched at a time. Illegal instructions arriving while in TRAP are squashed and do not overwrite TrapPC.
- No arithmetic inside the block except the optional counter.

Optional Feature:
- Macro: DE_BUBBLE_COUNT_EN.
- Defined:
  - Adds output BubbleCnt, 32 bits.
  - Increments by 1 on every edge that loads a bubble because of FlushE, trap entry, or the TRAP state.
  - Does not count ValidD = 0 or reset.
  - Wraps from 0xFFFFFFFF to 0. Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then pass-through:
  - Stimulus: assert rst mid-cycle; then drive ValidD = 1, CtrlD = 8'b1000_0000, RD1D = 0x11, RD2D = 0x22, ImmExtD = 0x4, PCD = 0x100, RdD = 5.
  - Required: immediately after rst all outputs are 0. Next edge after release: ValidE = 1 and every E output equals the values driven.
- Stall: hold StallE = 1 for 3 cycles while the D inputs change every cycle -> E outputs hold the pre-stall values. Release: the current D values appear after 1 edge.
- Flush beats stall: StallE = 1, FlushE = 1, IllegalOpD = 1, PCD = 0x200 -> ValidE = 0, CtrlE = 0, TrapE stays 0, BubbleCnt +1.
- Trap entry and clear:
  - Stimulus: ValidD = 1, IllegalOpD = 1, PCD = 0x300. Then keep legal instructions flowing for 4 cycles, then pulse TrapClr.
  - Required: TrapE = 1 and TrapPC = 0x300 one edge after the illegal instruction. ValidE stays 0 for all 4 cycles. TrapE = 0 one edge after TrapClr. ValidE = 1 one edge later.
- Second illegal during TRAP: IllegalOpD = 1 with PCD = 0x400 while in TRAP -> TrapPC remains 0x300.
- Wrap (feature enabled): force BubbleCnt = 0xFFFFFFFF, then FlushE = 1 for 1 cycle -> BubbleCnt = 0.
